// File: rtl/q_frag_readback_if.sv
// rtl/q_frag_readback_if.sv - capture request, QZ sampling and serial readback stream signals
interface q_frag_readback_if #(
  parameter int WIDTH = 8
);
  logic             CAP_REQ;
  logic [WIDTH-1:0] QZ_BUS;
  logic             FREEZE;
  logic             BUSY;
  logic             SDO;
  logic             SDO_VALID;
  logic             SDO_READY;
  logic             SDO_LAST;
  logic             DONE;

  modport master (
    output CAP_REQ, QZ_BUS, SDO_READY,
    input  FREEZE, BUSY, SDO, SDO_VALID, SDO_LAST, DONE
  );

  modport slave (
    input  CAP_REQ, QZ_BUS, SDO_READY,
    output FREEZE, BUSY, SDO, SDO_VALID, SDO_LAST, DONE
  );
endinterface

// File: rtl/q_frag_readback.sv
// rtl/q_frag_readback.sv - snapshot of WIDTH flip-flop QZ outputs streamed out serially
// Optional trailing even-parity beat when Q_FRAG_READBACK_PARITY_EN is defined.
module q_frag_readback #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              QCK,
  input  logic              QRT_N,
  q_frag_readback_if.slave  bus
);

`ifdef Q_FRAG_READBACK_PARITY_EN
  localparam int NBEATS = WIDTH + 1;
`else
  localparam int NBEATS = WIDTH;
`endif
  localparam int CW = $clog2(NBEATS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBEATS - 1);
  localparam logic [CW-1:0] MSB_IDX  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, FINISH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    data_idx;
  logic [WIDTH-1:0] shifted;
  logic             beat_bit;
  logic             is_last;
  logic             beat_fire;

  assign is_last   = (cnt == LAST_IDX);
  assign beat_fire = (state == SHIFT) && bus.SDO_READY;
  assign data_idx  = MSB_FIRST ? (MSB_IDX - cnt) : cnt;
  assign shifted   = shadow >> data_idx;

`ifdef Q_FRAG_READBACK_PARITY_EN
  // The beat after the last data bit carries the even parity of the snapshot.
  assign beat_bit = (cnt == CW'(WIDTH)) ? ^shadow : shifted[0];
`else
  assign beat_bit = shifted[0];
`endif

  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shadow is loaded once per snapshot so later QZ_BUS changes cannot leak into the stream.
  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (state == CAPTURE) begin
      shadow <= bus.QZ_BUS;
      cnt    <= '0;
    end else if (beat_fire) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.FREEZE    = 1'b0;
    bus.BUSY      = 1'b0;
    bus.SDO       = 1'b0;
    bus.SDO_VALID = 1'b0;
    bus.SDO_LAST  = 1'b0;
    bus.DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CAP_REQ) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        bus.FREEZE = 1'b1;
        bus.BUSY   = 1'b1;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        bus.FREEZE    = 1'b1;
        bus.BUSY      = 1'b1;
        bus.SDO_VALID = 1'b1;
        bus.SDO       = beat_bit;
        bus.SDO_LAST  = is_last;
        if (bus.SDO_READY && is_last) state_nxt = FINISH;
      end
      FINISH: begin
        bus.BUSY  = 1'b1;
        bus.DONE  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_q_frag_readback.sv
// tb/tb_q_frag_readback.sv - randomized and directed checks of q_frag_readback against a queue model
module tb_q_frag_readback;
  localparam int WIDTH = 8;
`ifdef Q_FRAG_READBACK_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic QCK = 1'b0;
  logic QRT_N = 1'b0;
  always #5 QCK = ~QCK;

  q_frag_readback_if #(.WIDTH(WIDTH)) bm ();
  q_frag_readback_if #(.WIDTH(WIDTH)) bl ();

  q_frag_readback #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (.QCK(QCK), .QRT_N(QRT_N), .bus(bm));
  q_frag_readback #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (.QCK(QCK), .QRT_N(QRT_N), .bus(bl));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: expected beats still to be delivered, plus busy/capture/done flags.
  bit busy_m, capt_m, done_m;
  bit q_m[$];
  bit q_l[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (q_m.size() > 0) && !capt_m;
    check("busy_msb",   bm.BUSY,      busy_m);
    check("busy_lsb",   bl.BUSY,      busy_m);
    check("freeze_msb", bm.FREEZE,    busy_m && !done_m);
    check("freeze_lsb", bl.FREEZE,    busy_m && !done_m);
    check("valid_msb",  bm.SDO_VALID, v);
    check("valid_lsb",  bl.SDO_VALID, v);
    check("sdo_msb",    bm.SDO,       v ? q_m[0] : 1'b0);
    check("sdo_lsb",    bl.SDO,       v ? q_l[0] : 1'b0);
    check("last_msb",   bm.SDO_LAST,  v && (q_m.size() == 1));
    check("last_lsb",   bl.SDO_LAST,  v && (q_l.size() == 1));
    check("done_msb",   bm.DONE,      done_m);
    check("done_lsb",   bl.DONE,      done_m);
  endtask

  task automatic model_edge(input bit cap, input logic [WIDTH-1:0] qz, input bit rdy);
    if (done_m) begin
      done_m = 1'b0;
      busy_m = 1'b0;
    end else if (capt_m) begin
      capt_m = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        q_m.push_back(qz[WIDTH-1-i]);
        q_l.push_back(qz[i]);
      end
`ifdef Q_FRAG_READBACK_PARITY_EN
      q_m.push_back(^qz);
      q_l.push_back(^qz);
`endif
    end else if (q_m.size() > 0) begin
      if (rdy) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
        if (q_m.size() == 0) done_m = 1'b1;
      end
    end else if (cap) begin
      busy_m = 1'b1;
      capt_m = 1'b1;
    end
  endtask

  task automatic step(input bit cap, input logic [WIDTH-1:0] qz, input bit rdy);
    bm.CAP_REQ = cap;  bl.CAP_REQ = cap;
    bm.QZ_BUS = qz;    bl.QZ_BUS = qz;
    bm.SDO_READY = rdy; bl.SDO_READY = rdy;
    @(posedge QCK);
    model_edge(cap, qz, rdy);
    @(negedge QCK);
    check_outputs();
  endtask

  task automatic do_reset();
    #2 QRT_N = 1'b0;
    #1;
    busy_m = 1'b0; capt_m = 1'b0; done_m = 1'b0;
    q_m.delete(); q_l.delete();
    check_outputs();
    @(negedge QCK);
    check_outputs();
    QRT_N = 1'b1;
  endtask

  task automatic run_directed(input logic [WIDTH-1:0] qz, input bit toggle, input bit corrupt,
                              input logic [15:0] exp_m, input logic [15:0] exp_l);
    logic [15:0] acc_m, acc_l;
    int beats, first_v, done_t;
    bit rdy, cap;
    logic [WIDTH-1:0] qz_t;
    acc_m = '0; acc_l = '0; beats = 0; first_v = -1; done_t = -1;
    step(1'b1, qz, 1'b1);
    for (int t = 1; t <= 40; t++) begin
      if (bm.SDO_VALID && first_v < 0) first_v = t;
      if (bm.DONE) begin
        done_t = t;
        break;
      end
      rdy  = toggle ? (t % 2 == 0) : 1'b1;
      cap  = corrupt && (t == 4);
      qz_t = (corrupt && t >= 2) ? 8'hFF : qz;
      if (bm.SDO_VALID && rdy) begin
        acc_m = {acc_m[14:0], bm.SDO};
        acc_l = {acc_l[14:0], bl.SDO};
        beats++;
      end
      step(cap, qz_t, rdy);
    end
    check("stream_msb", acc_m, exp_m);
    check("stream_lsb", acc_l, exp_l);
    check("beat_count", beats, NB);
    if (!toggle) begin
      check("first_valid_cycle", first_v, 2);
      check("done_cycle", done_t, NB + 2);
    end else begin
      check("done_seen", done_t > 0, 1'b1);
    end
    step(1'b0, qz, 1'b1);
  endtask

  initial begin
    int beats;
    bit cap_hold;
    bm.CAP_REQ = 1'b0; bl.CAP_REQ = 1'b0;
    bm.QZ_BUS = '0;    bl.QZ_BUS = '0;
    bm.SDO_READY = 1'b0; bl.SDO_READY = 1'b0;
    busy_m = 1'b0; capt_m = 1'b0; done_m = 1'b0;

    @(negedge QCK);
    check_outputs();
    @(negedge QCK);
    QRT_N = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h3C, 1'b1);

`ifdef Q_FRAG_READBACK_PARITY_EN
    run_directed(8'hA5, 1'b0, 1'b0, 16'h014A, 16'h014A);
    run_directed(8'hA5, 1'b1, 1'b0, 16'h014A, 16'h014A);
    run_directed(8'hA5, 1'b0, 1'b1, 16'h014A, 16'h014A);
    run_directed(8'h07, 1'b0, 1'b0, 16'h000F, 16'h01C1);
`else
    run_directed(8'hA5, 1'b0, 1'b0, 16'h00A5, 16'h00A5);
    run_directed(8'hA5, 1'b1, 1'b0, 16'h00A5, 16'h00A5);
    run_directed(8'hA5, 1'b0, 1'b1, 16'h00A5, 16'h00A5);
    run_directed(8'h07, 1'b0, 1'b0, 16'h0007, 16'h00E0);
`endif

    // Reset in the middle of beat 4, then a clean snapshot.
    beats = 0;
    step(1'b1, 8'hA5, 1'b1);
    for (int t = 0; t < 20 && beats < 4; t++) begin
      if (bm.SDO_VALID) beats++;
      step(1'b0, 8'hA5, 1'b1);
    end
    check("reset_reached_beat4", beats, 4);
    do_reset();
    check("post_reset_busy", bm.BUSY, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'hA5, 1'b1);
`ifdef Q_FRAG_READBACK_PARITY_EN
    run_directed(8'hA5, 1'b0, 1'b0, 16'h014A, 16'h014A);
`else
    run_directed(8'hA5, 1'b0, 1'b0, 16'h00A5, 16'h00A5);
`endif

    // Random traffic: pulsed or held requests, noisy QZ_BUS, random backpressure, rare resets.
    cap_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) cap_hold = ~cap_hold;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(cap_hold || ($urandom_range(0, 7) == 0), 8'($urandom),
             $urandom_range(0, 2) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
